reader_pie_encoder: RTL and testbench



---
 rtl/rfid_reader_pkg.sv | 37 +++
 rtl/pie_symbol_timer.sv | 52 +++++
 rtl/reader_pie_encoder.sv | 197 +++++++++++++++++++
 tb/tb_reader_pie_encoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rfid_reader_pkg.sv
// ---------------------------------------------------------------------------
// rfid_reader_pkg
// Shared types and constants for the reader-side Gen2 forward-link encoder:
// FSM state encoding, PIE symbol types, counter/operand widths and the
// Gen2 command opcodes used to build command vectors.
// ---------------------------------------------------------------------------
package rfid_reader_pkg;

   localparam int unsigned CNT_W   = 11;  // symbol counter, holds up to 2*1023
   localparam int unsigned TRCAL_W = 10;  // TRcal length operand
   localparam int unsigned LEN_W   = 6;   // command length / bit index

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELIM,
      ST_DATA0,
      ST_RTCAL,
      ST_TRCAL,
      ST_BITS,
      ST_DONE
   } pie_state_e;

   typedef enum logic [2:0] {
      SYM_DELIM,
      SYM_DATA0,
      SYM_DATA1,
      SYM_RTCAL,
      SYM_TRCAL
   } pie_sym_e;

   // Gen2 command opcodes (MSB-first prefixes of the command vector)
   localparam logic [3:0] OP_QUERY    = 4'b1000;
   localparam logic [1:0] OP_QUERYREP = 2'b00;
   localparam logic [1:0] OP_ACK      = 2'b01;
   localparam logic [7:0] OP_REQRN    = 8'hC1;

endpackage

// File: rtl/pie_symbol_timer.sv
// ---------------------------------------------------------------------------
// pie_symbol_timer
// Times one PIE symbol: high for (len - pw) cycles then low for pw cycles.
// A symbol with pw == len is entirely low (used for the delimiter).
//   clk, reset    : clock, async active-low reset
//   i_load        : start a new symbol; this cycle's edge starts its first cycle
//   i_clear       : abandon the symbol and return the line to carrier-on
//   i_len, i_pw   : symbol length and trailing low width, in cycles
//   o_level       : registered line level for the current cycle
//   o_sym_end_c   : current cycle is the last cycle of the symbol
// ---------------------------------------------------------------------------
module pie_symbol_timer
   import rfid_reader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_len,
   input  logic [CNT_W-1:0] i_pw,
   output logic             o_level,
   output logic             o_sym_end_c
);

   // r_cnt = cycles still to come in this symbol after the current one
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_pw;
   logic             r_level;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_pw    <= '0;
         r_level <= 1'b1;
      end else if (i_clear) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else if (i_load) begin
         r_cnt   <= i_len - CNT_W'(1);
         r_pw    <= i_pw;
         r_level <= (i_len > i_pw);
      end else if (r_cnt != '0) begin
         // next cycle is low once it falls within the final pw cycles
         r_cnt   <= r_cnt - CNT_W'(1);
         r_level <= ((r_cnt - CNT_W'(1)) >= r_pw);
      end
   end

   assign o_level     = r_level;
   assign o_sym_end_c = (r_cnt == '0);

endmodule

// File: rtl/reader_pie_encoder.sv
// ---------------------------------------------------------------------------
// reader_pie_encoder
// Gen2 reader forward-link PIE transmitter: delimiter, data-0, RTcal,
// optional TRcal, then the command bits MSB-first.
//   clk, reset  : clock, async active-low reset
//   start       : request a frame (sampled only in IDLE)
//   frame_sync  : 1 = frame-sync (no TRcal), 0 = full preamble
//   cmd_bits    : command vector, bit cmd_len-1 sent first
//   cmd_len     : number of bits to send (clamped to MAXBITS)
//   trcal_clks  : TRcal length (raised to 2*PW_CLKS if shorter)
//   abort       : end the frame immediately, no done pulse
//   pie_out     : 1 = carrier on, 0 = modulation low
//   busy        : frame in progress
//   done        : one-cycle pulse after a completed frame
// ---------------------------------------------------------------------------
module reader_pie_encoder
   import rfid_reader_pkg::*;
#(
   parameter int unsigned TARI_CLKS  = 8,
   parameter int unsigned DATA1_CLKS = 16,
   parameter int unsigned PW_CLKS    = 4,
   parameter int unsigned DELIM_CLKS = 5,
   parameter int unsigned MAXBITS    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               frame_sync,
   input  logic [MAXBITS-1:0] cmd_bits,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [TRCAL_W-1:0] trcal_clks,
   input  logic               abort,
   output logic               pie_out,
   output logic               busy,
   output logic               done
);

   localparam int unsigned        IDX_W     = (MAXBITS > 1) ? $clog2(MAXBITS) : 1;
   localparam logic [LEN_W-1:0]   MAX_LEN   = LEN_W'(MAXBITS);
   localparam logic [TRCAL_W-1:0] MIN_TRCAL = TRCAL_W'(2 * PW_CLKS);

   pie_state_e         r_state;
   logic               r_fs;
   logic [MAXBITS-1:0] r_cmd;
   logic [LEN_W-1:0]   r_len;
   logic [TRCAL_W-1:0] r_trcal;
   logic [LEN_W-1:0]   r_idx;
   logic               r_busy;
   logic               r_done;

   pie_state_e         w_next_state;
   pie_sym_e           w_sym;
   pie_sym_e           w_bit_sym;
   logic               w_load;
   logic               w_clear;
   logic               w_sym_end;
   logic               w_level;
   logic [LEN_W-1:0]   w_next_idx;
   logic [CNT_W-1:0]   w_len;
   logic [CNT_W-1:0]   w_pw;

   // Index of the next data bit: first bit on entry, else one below current
   assign w_next_idx = (r_state == ST_BITS) ? (r_idx - LEN_W'(1)) : (r_len - LEN_W'(1));
   assign w_bit_sym  = r_cmd[IDX_W'(w_next_idx)] ? SYM_DATA1 : SYM_DATA0;

   // Next state and symbol to load at this edge
   always_comb begin
      w_next_state = r_state;
      w_sym        = SYM_DATA0;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_DELIM;
               w_sym        = SYM_DELIM;
               w_load       = 1'b1;
            end
         end
         ST_DELIM: begin
            if (w_sym_end) begin
               w_next_state = ST_DATA0;
               w_sym        = SYM_DATA0;
               w_load       = 1'b1;
            end
         end
         ST_DATA0: begin
            if (w_sym_end) begin
               w_next_state = ST_RTCAL;
               w_sym        = SYM_RTCAL;
               w_load       = 1'b1;
            end
         end
         ST_RTCAL, ST_TRCAL: begin
            if (w_sym_end) begin
               if ((r_state == ST_RTCAL) && !r_fs) begin
                  w_next_state = ST_TRCAL;
                  w_sym        = SYM_TRCAL;
                  w_load       = 1'b1;
               end else if (r_len == '0) begin
                  w_next_state = ST_DONE;
                  w_clear      = 1'b1;
               end else begin
                  w_next_state = ST_BITS;
                  w_sym        = w_bit_sym;
                  w_load       = 1'b1;
               end
            end
         end
         ST_BITS: begin
            if (w_sym_end) begin
               if (r_idx == '0) begin
                  w_next_state = ST_DONE;
                  w_clear      = 1'b1;
               end else begin
                  w_sym        = w_bit_sym;
                  w_load       = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
            w_clear      = 1'b1;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_clear      = 1'b1;
         end
      endcase
      // abort outranks any symbol completion in the same cycle
      if (abort && (r_state != ST_IDLE)) begin
         w_next_state = ST_IDLE;
         w_load       = 1'b0;
         w_clear      = 1'b1;
      end
   end

   // Symbol length and low-pulse width for the symbol being loaded
   always_comb begin
      w_len = CNT_W'(TARI_CLKS);
      w_pw  = CNT_W'(PW_CLKS);
      case (w_sym)
         SYM_DELIM: begin
            w_len = CNT_W'(DELIM_CLKS);
            w_pw  = CNT_W'(DELIM_CLKS);
         end
         SYM_DATA0: w_len = CNT_W'(TARI_CLKS);
         SYM_DATA1: w_len = CNT_W'(DATA1_CLKS);
         SYM_RTCAL: w_len = CNT_W'(TARI_CLKS + DATA1_CLKS);
         SYM_TRCAL: w_len = CNT_W'(r_trcal);
         default:   w_len = CNT_W'(TARI_CLKS);
      endcase
   end

   // FSM state, frame parameters and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_fs    <= 1'b0;
         r_cmd   <= '0;
         r_len   <= '0;
         r_trcal <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
         r_done  <= (w_next_state == ST_DONE);
         if ((r_state == ST_IDLE) && start) begin
            r_fs    <= frame_sync;
            r_cmd   <= cmd_bits;
            r_len   <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            r_trcal <= (trcal_clks < MIN_TRCAL) ? MIN_TRCAL : trcal_clks;
         end
         if (w_load && (w_next_state == ST_BITS)) begin
            r_idx <= w_next_idx;
         end
      end
   end

   pie_symbol_timer u_timer (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_clear     (w_clear),
      .i_len       (w_len),
      .i_pw        (w_pw),
      .o_level     (w_level),
      .o_sym_end_c (w_sym_end)
   );

   assign pie_out = w_level;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_reader_pie_encoder.sv
// ---------------------------------------------------------------------------
// tb_reader_pie_encoder
// Scoreboard bench: the driver expands each frame into its per-cycle
// {pie_out, busy, done} sequence from the symbol rules and queues it; the
// monitor pops one entry per cycle (idle when empty) and compares.
// ---------------------------------------------------------------------------
module tb_reader_pie_encoder;
   import rfid_reader_pkg::*;

   localparam int TARI  = 8;
   localparam int DATA1 = 16;
   localparam int PW    = 4;
   localparam int DELIM = 5;
   localparam int MAXB  = 32;

   logic        clk;
   logic        reset;
   logic        start;
   logic        frame_sync;
   logic [31:0] cmd_bits;
   logic [5:0]  cmd_len;
   logic [9:0]  trcal_clks;
   logic        abort;
   logic        pie_out;
   logic        busy;
   logic        done;

   reader_pie_encoder #(
      .TARI_CLKS  (TARI),
      .DATA1_CLKS (DATA1),
      .PW_CLKS    (PW),
      .DELIM_CLKS (DELIM),
      .MAXBITS    (MAXB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_sync (frame_sync),
      .cmd_bits   (cmd_bits),
      .cmd_len    (cmd_len),
      .trcal_clks (trcal_clks),
      .abort      (abort),
      .pie_out    (pie_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] sb_q[$];     // expected {pie, busy, done} per cycle
   logic [2:0] frame_q[$];  // full model frame being built
   int         vectors;
   int         miscompares;
   int         cyc;
   bit         mon_en;

   // Watchdog: bounded run time
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within the wait budget");
      $finish;
   end

   // Monitor: one comparison per cycle, away from the active edge
   always @(negedge clk) begin
      logic [2:0] exp_v;
      cyc <= cyc + 1;
      if (mon_en) begin
         exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 3'b100;
         vectors <= vectors + 1;
         if ({pie_out, busy, done} !== exp_v) begin
            miscompares <= miscompares + 1;
            $display("FAIL cycle%0d pie/busy/done got %b want %b", cyc, {pie_out, busy, done}, exp_v);
         end
      end
   end

   task automatic add_sym(input int len, input int pw);
      for (int i = 0; i < len - pw; i++) frame_q.push_back(3'b110);
      for (int i = 0; i < pw; i++) frame_q.push_back(3'b010);
   endtask

   // Reference frame: delimiter, data-0, RTcal, [TRcal], bits, done cycle
   task automatic model_frame(input bit fs, input logic [31:0] bits, input int len, input int trcal);
      int n;
      int tr;
      n  = (len > MAXB) ? MAXB : len;
      tr = (trcal < 2 * PW) ? 2 * PW : trcal;
      frame_q.delete();
      for (int i = 0; i < DELIM; i++) frame_q.push_back(3'b010);
      add_sym(TARI, PW);
      add_sym(TARI + DATA1, PW);
      if (!fs) add_sym(tr, PW);
      for (int b = n - 1; b >= 0; b--) add_sym(bits[b] ? DATA1 : TARI, PW);
      frame_q.push_back(3'b101);
   endtask

   // mode: 0 = run to completion, 1 = abort in cycle cut, 2 = reset in cycle cut
   task automatic run_frame(input bit fs, input logic [31:0] bits, input int len,
                            input int trcal, input int mode, input int cut, input bit spurious);
      int total;
      int keep;
      @(posedge clk);
      #1;
      frame_sync = fs;
      cmd_bits   = bits;
      cmd_len    = 6'(len);
      trcal_clks = 10'(trcal);
      start      = 1'b1;
      @(posedge clk);
      model_frame(fs, bits, len, trcal);
      total = frame_q.size();
      keep  = total;
      if (mode == 1) begin
         total = cut;
         keep  = cut;
      end else if (mode == 2) begin
         total = cut;
         keep  = cut - 1;
      end
      for (int i = 0; i < keep; i++) sb_q.push_back(frame_q[i]);
      #1;
      start      = 1'b0;
      frame_sync = 1'($urandom);
      cmd_bits   = $urandom;
      cmd_len    = 6'($urandom);
      trcal_clks = 10'($urandom);
      for (int c = 1; c <= total; c++) begin
         start = spurious && ($urandom_range(0, 2) == 0);
         if (mode == 1 && c == cut) abort = 1'b1;
         if (mode == 2 && c == cut) reset = 1'b0;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
      start = 1'b0;
      if (mode == 2) begin
         @(posedge clk);
         #3;
         reset = 1'b1;
      end
   endtask

   initial begin
      int mode;
      int cut;
      int len;
      int tr;
      bit fs;
      int reset_errs;
      vectors     = 0;
      miscompares = 0;
      reset_errs  = 0;
      cyc         = 0;
      mon_en      = 1'b0;
      reset       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      frame_sync  = 1'b0;
      cmd_bits    = '0;
      cmd_len     = '0;
      trcal_clks  = '0;
      #21;
      if ({pie_out, busy, done} !== 3'b100) begin
         reset_errs++;
         $display("FAIL reset state pie/busy/done got %b want 100", {pie_out, busy, done});
      end
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      run_frame(1'b0, 32'h2, 2, 40, 0, 0, 1'b0);             // full preamble
      run_frame(1'b1, 32'h0, 4, 40, 0, 0, 1'b0);             // frame-sync
      run_frame(1'b0, 32'h0, 0, 40, 0, 0, 1'b0);             // zero-length
      run_frame(1'b0, $urandom, 40, 3, 0, 0, 1'b0);          // clamping
      run_frame(1'b0, $urandom, 8, 40, 1, 20, 1'b0);         // abort at 20
      run_frame(1'b1, {30'h0, OP_QUERYREP}, 2, 40, 0, 0, 1'b0);
      run_frame(1'b0, $urandom, 16, 40, 2, 30, 1'b1);        // reset at 30
      run_frame(1'b0, {24'h0, 4'hA, OP_QUERY}, 8, 24, 0, 0, 1'b1);
      run_frame(1'b1, {22'h0, OP_ACK, 8'h5A}, 10, 40, 0, 0, 1'b1);
      run_frame(1'b1, {24'h0, OP_REQRN}, 8, 40, 1, 1, 1'b0);  // abort first cycle

      for (int f = 0; f < 40; f++) begin
         fs   = 1'($urandom);
         len  = $urandom_range(0, 40);
         tr   = $urandom_range(0, 200);
         model_frame(fs, 32'h0, 0, tr);
         mode = $urandom_range(0, 5);
         mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
         // cut lands inside the preamble, which never exceeds the frame length
         cut  = $urandom_range(1, frame_q.size() - 1);
         run_frame(fs, $urandom, len, tr, mode, cut, 1'($urandom));
      end

      repeat (6) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares == 0 && reset_errs == 0) $display("PASS");
      else $display("FAIL");
      $finish;
   end

endmodule
